// File: rtl/inst_loader_pkg.sv
// Shared types and parameters for the boot-time instruction loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

  localparam int AddrWidth = 32;
  localparam int InstWidth = 32;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [InstWidth-1:0] inst_t;

  localparam addr_t InstStartFrom  = 32'h0000_1000;
  localparam int    InstSpace      = 4096;
  localparam int    LoaderMaxWords = InstSpace >> 2;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } loader_state_t;

  // Byte address of word 'index'; the offset wraps at the address width.
  function automatic addr_t word_addr(input addr_t base, input logic [15:0] index);
    addr_t offset;
    offset = addr_t'(index) << 2;
    return base + offset;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word.
// word_full flags the strobe that completes the current word.
module word_assembler
  import inst_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       byte_strobe,
  input  logic [7:0] byte_data,
  output inst_t      word,
  output logic       word_full
);

  logic [1:0] byte_count;

  // Shifting right places the first byte of each group of four in bits [7:0].
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_count <= 2'd0;
      word       <= '0;
    end else if (byte_strobe) begin
      byte_count <= byte_count + 2'd1;
      word       <= {byte_data, word[31:8]};
    end
  end

  assign word_full = byte_strobe && (byte_count == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot-time loader: byte stream in, 32-bit instruction writes out to the fetch stage.
// Optional checksum trailer word is compiled in with LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter addr_t StartAddr = InstStartFrom,
  parameter int    MaxWords  = LoaderMaxWords
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  addr_t       pc_addr,
  output addr_t       fetch_addr,
  output logic        fetch_load,
  output inst_t       fetch_load_inst,
  output logic        fetch_cs,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MaxWordsU = MaxWords;

  loader_state_t state, state_next;
  logic [15:0]   index;
  logic [15:0]   num_words_q;
  logic          done_q;
  logic          error_q;
  inst_t         word;
  logic          word_full;
  logic          byte_strobe;
  logic          start_taken;
  logic          start_over;
  logic          start_zero;
  logic          last_word;
`ifdef LOADER_CHECKSUM_EN
  inst_t         sum;
`endif

  assign start_taken = start && ((state == IDLE) || (state == DONE));
  assign start_over  = {16'd0, num_words} > MaxWordsU;
  assign start_zero  = (num_words == 16'd0);
  assign byte_strobe = byte_valid && byte_ready;
  assign last_word   = (index == num_words_q - 16'd1);

  word_assembler u_word_assembler (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_taken),
    .byte_strobe (byte_strobe),
    .byte_data   (byte_data),
    .word        (word),
    .word_full   (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (start_over)      state_next = IDLE;
          else if (start_zero) state_next = DONE;
          else                 state_next = RECV;
        end
      end
      RECV: if (word_full) state_next = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (word_full) state_next = DONE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Session bookkeeping: word index, latched length and the sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      index       <= 16'd0;
      num_words_q <= 16'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      if (start_taken) begin
        if (start_over) begin
          error_q <= 1'b1;
          done_q  <= 1'b0;
        end else if (start_zero) begin
          done_q  <= 1'b1;
          error_q <= 1'b0;
        end else begin
          done_q      <= 1'b0;
          error_q     <= 1'b0;
          index       <= 16'd0;
          num_words_q <= num_words;
`ifdef LOADER_CHECKSUM_EN
          sum         <= '0;
`endif
        end
      end
      if (state == WRITE) begin
`ifdef LOADER_CHECKSUM_EN
        sum <= sum + word;
`endif
        if (last_word) begin
`ifndef LOADER_CHECKSUM_EN
          done_q <= 1'b1;
`endif
        end else begin
          index <= index + 16'd1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      // The completing byte is still on the bus, so splice it onto the three held bytes.
      if ((state == CHECK) && word_full) begin
        done_q  <= 1'b1;
        error_q <= ({byte_data, word[31:8]} != sum);
      end
`endif
    end
  end

  always_comb begin
    fetch_addr      = pc_addr;
    fetch_cs        = 1'b1;
    fetch_load      = 1'b0;
    fetch_load_inst = '0;
    byte_ready      = 1'b0;
    busy            = 1'b0;
    case (state)
      RECV: begin
        byte_ready = 1'b1;
        fetch_cs   = 1'b0;
        busy       = 1'b1;
      end
      WRITE: begin
        fetch_addr      = word_addr(StartAddr, index);
        fetch_load      = 1'b1;
        fetch_load_inst = word;
        busy            = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        fetch_cs   = 1'b0;
        busy       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign done  = done_q;
  assign error = error_q;

endmodule
